// File: rtl/uart_cmd_decoder_pkg.sv
// Shared constants for the UART command link: command nibbles,
// reply bytes, FSM encodings and the Hamming(7,4) syndrome helper.
package uart_cmd_decoder_pkg;

    localparam logic [3:0] CMD_TURN_ON  = 4'h6;
    localparam logic [3:0] CMD_TURN_OFF = 4'hD;

    localparam logic [7:0] ACK_DEFAULT  = 8'h3C;
    localparam logic [7:0] NACK_DEFAULT = 8'hC3;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DECODE   = 2'd1;
    localparam logic [1:0] S_ACK_REQ  = 2'd2;
    localparam logic [1:0] S_ACK_WAIT = 2'd3;

    // Syndrome {s3,s2,s1}; code[k-1] holds position k.
    // A nonzero value names the position in error.
    function automatic logic [2:0] hamming_syndrome(input logic [6:0] c);
        logic s1, s2, s3;
        s1 = c[0] ^ c[2] ^ c[4] ^ c[6];
        s2 = c[1] ^ c[2] ^ c[5] ^ c[6];
        s3 = c[3] ^ c[4] ^ c[5] ^ c[6];
        return {s3, s2, s1};
    endfunction

endpackage

// File: rtl/hamming_7_4_decoder.sv
// Combinational Hamming(7,4) decoder, inverse of hamming_7_4_encoder.
// Single-bit errors are corrected; double errors are miscorrected.
module hamming_7_4_decoder
    import uart_cmd_decoder_pkg::*;
(
    input  logic [6:0] code_in,
    output logic [3:0] data_out,
    output logic       corrected
);

    logic [2:0] syn;
    logic [6:0] fixed;

    // Flip the position the syndrome points at, then extract d3..d0.
    always_comb begin
        syn   = hamming_syndrome(code_in);
        fixed = code_in;
        if (syn != 3'd0) begin
            fixed[syn - 3'd1] = ~code_in[syn - 3'd1];
        end
        data_out  = {fixed[6], fixed[5], fixed[4], fixed[2]};
        corrected = (syn != 3'd0);
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Validates Hamming-protected command frames from uart_rx, strobes the
// decoded command and replies ACK/NACK through the uart_tx handshake.
module uart_cmd_decoder
    import uart_cmd_decoder_pkg::*;
#(
    parameter logic [7:0]  ACK_BYTE   = ACK_DEFAULT,
    parameter logic [7:0]  NACK_BYTE  = NACK_DEFAULT,
    parameter bit          ACK_ENABLE = 1'b1,
    parameter int unsigned TX_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_received,
    input  logic       rx_done,
    input  logic       parity_error,
    input  logic       tx_busy,
    output logic [7:0] data_to_tx,
    output logic       start_tx,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    output logic       cmd_corrected,
    output logic [7:0] err_count
);

    localparam logic [15:0] TMO = 16'(TX_TIMEOUT);

    logic [1:0]  state;
    logic [7:0]  hold_data;
    logic        hold_perr;
    logic        hold_full;
    logic [7:0]  frame_data;
    logic        frame_perr;
    logic [15:0] tmo_cnt;

    logic [3:0]  dec_data;
    logic        dec_corr;
    logic        consume;
    logic        overrun;
    logic        accept;
    logic        reject;
    logic        timeout;
    logic [9:0]  err_sum;
    logic [7:0]  err_next;

    hamming_7_4_decoder u_ham (
        .code_in   (frame_data[6:0]),
        .data_out  (dec_data),
        .corrected (dec_corr)
    );

    // Error events and the saturating error-counter update.
    always_comb begin
        consume  = (state == S_IDLE) && hold_full;
        overrun  = rx_done && hold_full && !consume;
        accept   = !frame_perr && frame_data[7];
        reject   = (state == S_DECODE) && !accept;
        timeout  = (state == S_ACK_REQ) && !tx_busy && (tmo_cnt == TMO);
        err_sum  = {2'b00, err_count} + {9'd0, overrun}
                 + {9'd0, reject} + {9'd0, timeout};
        err_next = (err_sum > 10'd255) ? 8'hFF : err_sum[7:0];
    end

    // Holding register: one byte and parity flag waiting for the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_data <= 8'd0;
            hold_perr <= 1'b0;
            hold_full <= 1'b0;
        end else if (rx_done && (!hold_full || consume)) begin
            hold_data <= data_received;
            hold_perr <= parity_error;
            hold_full <= 1'b1;
        end else if (consume) begin
            hold_full <= 1'b0;
        end
    end

    // Frame register snapshot taken when the FSM consumes the held byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_data <= 8'd0;
            frame_perr <= 1'b0;
        end else if (consume) begin
            frame_data <= hold_data;
            frame_perr <= hold_perr;
        end
    end

    // Error counter, saturating at 8'hFF.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= 8'd0;
        end else begin
            err_count <= err_next;
        end
    end

    // Control FSM: decode, strobe the command, run the reply handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            tmo_cnt       <= 16'd0;
            data_to_tx    <= 8'd0;
            start_tx      <= 1'b0;
            cmd           <= 4'd0;
            cmd_valid     <= 1'b0;
            cmd_corrected <= 1'b0;
        end else begin
            cmd_valid     <= 1'b0;
            cmd_corrected <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (hold_full) begin
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (accept) begin
                        cmd           <= dec_data;
                        cmd_valid     <= 1'b1;
                        cmd_corrected <= dec_corr;
                        data_to_tx    <= ACK_BYTE;
                    end else begin
                        data_to_tx    <= NACK_BYTE;
                    end
                    tmo_cnt <= 16'd1;
                    if (ACK_ENABLE) begin
                        start_tx <= 1'b1;
                        state    <= S_ACK_REQ;
                    end else begin
                        state    <= S_IDLE;
                    end
                end
                S_ACK_REQ: begin
                    if (tx_busy) begin
                        start_tx <= 1'b0;
                        state    <= S_ACK_WAIT;
                    end else if (timeout) begin
                        start_tx <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        tmo_cnt  <= tmo_cnt + 16'd1;
                    end
                end
                S_ACK_WAIT: begin
                    if (!tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: expected commands and replies
// are queued at stimulus time and checked as the DUT produces them.
module tb_uart_cmd_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_received;
    logic       rx_done;
    logic       parity_error;
    logic       tx_busy;
    logic [7:0] data_to_tx;
    logic       start_tx;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       cmd_corrected;
    logic [7:0] err_count;

    int vectors = 0;
    int miscompares = 0;
    int exp_err = 0;
    logic       start_prev = 1'b0;
    logic [4:0] cmd_q[$];
    logic [7:0] reply_q[$];

    always #5 clk = ~clk;

    uart_cmd_decoder #(.TX_TIMEOUT(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_received (data_received),
        .rx_done       (rx_done),
        .parity_error  (parity_error),
        .tx_busy       (tx_busy),
        .data_to_tx    (data_to_tx),
        .start_tx      (start_tx),
        .cmd           (cmd),
        .cmd_valid     (cmd_valid),
        .cmd_corrected (cmd_corrected),
        .err_count     (err_count)
    );

    // Scoreboard monitor: pop expectations on cmd strobe / start_tx rise.
    always @(negedge clk) begin
        logic [4:0] ec;
        logic [7:0] er;
        if (!reset && cmd_valid === 1'b1) begin
            vectors++;
            if (cmd_q.size() == 0) begin
                miscompares++;
                $display("FAIL cmd_unexpected: cmd=%h corr=%b, none expected",
                         cmd, cmd_corrected);
            end else begin
                ec = cmd_q.pop_front();
                if ({cmd, cmd_corrected} !== ec) begin
                    miscompares++;
                    $display("FAIL cmd: got cmd=%h corr=%b, want cmd=%h corr=%b",
                             cmd, cmd_corrected, ec[4:1], ec[0]);
                end
            end
        end
        if (!reset && start_tx === 1'b1 && start_prev !== 1'b1) begin
            vectors++;
            if (reply_q.size() == 0) begin
                miscompares++;
                $display("FAIL reply_unexpected: data_to_tx=%h, none expected",
                         data_to_tx);
            end else begin
                er = reply_q.pop_front();
                if (data_to_tx !== er) begin
                    miscompares++;
                    $display("FAIL reply: got %h, want %h", data_to_tx, er);
                end
            end
        end
        start_prev = start_tx;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic pe);
        @(negedge clk);
        data_received = b;
        parity_error  = pe;
        rx_done       = 1'b1;
        @(negedge clk);
        rx_done       = 1'b0;
        parity_error  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_err = 0;
    endtask

    task automatic wait_start(output bit ok);
        int n = 0;
        while (start_tx !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (start_tx === 1'b1);
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL start_wait: start_tx=%b after %0d cycles, want 1",
                     start_tx, n);
        end
    endtask

    task automatic serve_tx(input int dly, input int hold);
        bit ok;
        wait_start(ok);
        if (ok) begin
            repeat (dly) @(negedge clk);
            tx_busy = 1'b1;
            @(negedge clk);
            vectors++;
            if (start_tx !== 1'b0) begin
                miscompares++;
                $display("FAIL start_drop: start_tx=%b, want 0", start_tx);
            end
            repeat (hold) @(negedge clk);
            tx_busy = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_done = 1'b0;
        parity_error = 1'b0;
        data_received = 8'h00;
        tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({data_to_tx, start_tx, cmd, cmd_valid, cmd_corrected, err_count}
            !== 23'd0) begin
            miscompares++;
            $display("FAIL reset: tx=%h st=%b cmd=%h v=%b c=%b err=%h, want 0",
                     data_to_tx, start_tx, cmd, cmd_valid, cmd_corrected,
                     err_count);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cmd_on();
        cmd_q.push_back({4'h6, 1'b0});
        reply_q.push_back(8'h3C);
        send_byte(8'hB3, 1'b0);
        @(negedge clk);
        vectors++;
        if (cmd_valid !== 1'b0 || start_tx !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: v=%b st=%b, want 0 0",
                     cmd_valid, start_tx);
        end
        @(negedge clk);
        vectors++;
        if (cmd_valid !== 1'b1 || start_tx !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_2: v=%b st=%b, want 1 1",
                     cmd_valid, start_tx);
        end
        serve_tx(3, 2);
        vectors++;
        if (err_count !== 8'd0 || cmd_q.size() != 0 || reply_q.size() != 0) begin
            miscompares++;
            $display("FAIL cmd_on_end: err=%h pend=%0d/%0d, want 0 0/0",
                     err_count, cmd_q.size(), reply_q.size());
        end
    endtask

    task automatic test_correct();
        cmd_q.push_back({4'hD, 1'b0});
        reply_q.push_back(8'h3C);
        send_byte(8'hE6, 1'b0);
        serve_tx(3, 2);
        cmd_q.push_back({4'hD, 1'b1});
        reply_q.push_back(8'h3C);
        send_byte(8'hE4, 1'b0);
        serve_tx(1, 1);
        vectors++;
        if (cmd_q.size() != 0 || reply_q.size() != 0) begin
            miscompares++;
            $display("FAIL correct_pending: %0d/%0d left, want 0/0",
                     cmd_q.size(), reply_q.size());
        end
    endtask

    task automatic test_reject();
        reply_q.push_back(8'hC3);
        send_byte(8'h33, 1'b0);
        serve_tx(2, 1);
        reply_q.push_back(8'hC3);
        send_byte(8'hB3, 1'b1);
        serve_tx(2, 1);
        exp_err = 2;
        vectors++;
        if (err_count !== 8'(exp_err)) begin
            miscompares++;
            $display("FAIL reject_err: err=%0d, want %0d", err_count, exp_err);
        end
        vectors++;
        if (cmd !== 4'hD || reply_q.size() != 0) begin
            miscompares++;
            $display("FAIL reject_hold: cmd=%h pend=%0d, want D 0",
                     cmd, reply_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        apply_reset();
        cmd_q.push_back({4'h6, 1'b0});
        reply_q.push_back(8'h3C);
        send_byte(8'hB3, 1'b0);
        wait_start(ok);
        tx_busy = 1'b1;
        repeat (2) @(negedge clk);
        cmd_q.push_back({4'hD, 1'b0});
        reply_q.push_back(8'h3C);
        data_received = 8'hE6;
        rx_done = 1'b1;
        @(negedge clk);
        data_received = 8'hB3;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (4) @(negedge clk);
        exp_err = 1;
        vectors++;
        if (err_count !== 8'(exp_err) || cmd_q.size() != 1) begin
            miscompares++;
            $display("FAIL overrun: err=%0d pend=%0d, want %0d 1",
                     err_count, cmd_q.size(), exp_err);
        end
        tx_busy = 1'b0;
        serve_tx(2, 1);
        vectors++;
        if (err_count !== 8'(exp_err) || cmd_q.size() != 0
            || reply_q.size() != 0) begin
            miscompares++;
            $display("FAIL overrun_end: err=%0d pend=%0d/%0d, want %0d 0/0",
                     err_count, cmd_q.size(), reply_q.size(), exp_err);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n = 0;
        apply_reset();
        cmd_q.push_back({4'h6, 1'b0});
        reply_q.push_back(8'h3C);
        send_byte(8'hB3, 1'b0);
        wait_start(ok);
        while (start_tx === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        exp_err = 1;
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL timeout_len: start_tx high %0d cycles, want 16", n);
        end
        vectors++;
        if (err_count !== 8'(exp_err)) begin
            miscompares++;
            $display("FAIL timeout_err: err=%0d, want %0d", err_count, exp_err);
        end
        cmd_q.push_back({4'hD, 1'b0});
        reply_q.push_back(8'h3C);
        send_byte(8'hE6, 1'b0);
        serve_tx(2, 1);
        vectors++;
        if (cmd_q.size() != 0 || reply_q.size() != 0) begin
            miscompares++;
            $display("FAIL timeout_next: %0d/%0d pending, want 0/0",
                     cmd_q.size(), reply_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        cmd_q.push_back({4'h6, 1'b0});
        reply_q.push_back(8'h3C);
        send_byte(8'hB3, 1'b0);
        wait_start(ok);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (start_tx !== 1'b0 || err_count !== 8'd0 || cmd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: st=%b err=%0d v=%b, want 0 0 0",
                     start_tx, err_count, cmd_valid);
        end
        reset = 1'b0;
        exp_err = 0;
        @(negedge clk);
        cmd_q.push_back({4'h6, 1'b0});
        reply_q.push_back(8'h3C);
        send_byte(8'hB3, 1'b0);
        serve_tx(3, 2);
        vectors++;
        if (cmd !== 4'h6 || cmd_q.size() != 0 || reply_q.size() != 0) begin
            miscompares++;
            $display("FAIL post_reset: cmd=%h pend=%0d/%0d, want 6 0/0",
                     cmd, cmd_q.size(), reply_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_cmd_on();
        test_correct();
        test_reject();
        test_back_to_back();
        test_timeout();
        test_reset_midflight();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
